// File: rtl/demux_scan_pkg.sv
// Shared definitions for the demux scan sequencer.
//   state_t  : sequencer FSM states
//   NUM_CH   : number of demux output channels
//   CNT_W    : width of the dwell/gap counter
//   cnt_load : converts a cycle count into the counter load value (count-1)
package demux_scan_pkg;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Counter counts down to 0, so N cycles means loading N-1.
  // A zero count is clamped so GAP=0 never underflows.
  function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
    if (cycles <= 0) begin
      return '0;
    end
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/demux_next_chan.sv
// Combinational next-channel finder.
//   mask     in  channel enable mask
//   cur_idx  in  current channel index
//   first    in  1 = search from below channel 0 (used at frame accept)
//   next_idx out lowest set mask index strictly above cur_idx (or >= 0 when first)
//   found    out 1 when such an index exists
module demux_next_chan
  import demux_scan_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [1:0]        cur_idx,
  input  logic              first,
  output logic [1:0]        next_idx,
  output logic              found
);

  // Scanning downward lets the lowest qualifying index win the last write.
  always_comb begin
    next_idx = '0;
    found    = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(cur_idx)))) begin
        next_idx = 2'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_scan_sequencer.sv
// Upstream driver for a 1-to-4 demux. Accepts a 4-bit frame plus channel mask,
// then scans enabled channels in ascending order, holding Enable for DWELL
// cycles per channel with GAP idle cycles in between, and pulses done.
//
// Handshake: start_ready is high only in IDLE; a frame is accepted on a rising
// edge where start_valid & start_ready. Inputs are ignored at all other times
// and latched frame values never change mid-frame.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start_valid/ready  frame request handshake
//   frame_data         per-channel data bits, captured at accept
//   chan_mask          per-channel enables, captured at accept
//   A                  demux data input
//   S0, S1             demux selects (S0 = index bit 1, S1 = index bit 0)
//   Enable             demux enable
//   active_chan        channel currently driven (0 when idle/done)
//   busy               high from the cycle after accept through done
//   done               one-cycle end-of-frame pulse
//   dbg_state          current FSM state, for observation
module demux_scan_sequencer
  import demux_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int GAP   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [NUM_CH-1:0] frame_data,
  input  logic [NUM_CH-1:0] chan_mask,
  output logic              A,
  output logic              S0,
  output logic              S1,
  output logic              Enable,
  output logic [1:0]        active_chan,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam logic [CNT_W-1:0] DWELL_LD = cnt_load(DWELL);
  localparam logic [CNT_W-1:0] GAP_LD   = cnt_load(GAP);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         chan_q, chan_d;
  logic [NUM_CH-1:0]  data_q, data_d;
  logic [NUM_CH-1:0]  mask_q, mask_d;

  logic               start_ready_q, start_ready_d;
  logic               a_q, a_d;
  logic               s0_q, s0_d;
  logic               s1_q, s1_d;
  logic               enable_q, enable_d;
  logic [1:0]         active_chan_q, active_chan_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept;
  logic [NUM_CH-1:0]  nc_mask;
  logic               nc_first;
  logic [1:0]         nc_idx;
  logic               nc_found;

  // Gate with the registered ready so nothing is accepted in the cycle where
  // ready is still low right after reset.
  assign accept = start_valid && start_ready_q && (state_q == S_IDLE);

  // In IDLE the finder looks at the incoming mask to pick the first channel;
  // otherwise it searches the latched mask above the current channel.
  always_comb begin
    nc_mask  = mask_q;
    nc_first = 1'b0;
    if (state_q == S_IDLE) begin
      nc_mask  = chan_mask;
      nc_first = 1'b1;
    end
  end

  demux_next_chan u_next_chan (
    .mask     (nc_mask),
    .cur_idx  (chan_q),
    .first    (nc_first),
    .next_idx (nc_idx),
    .found    (nc_found)
  );

  // ---------------------------------------------------------------------------
  // State register (also holds counter and latched frame)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      chan_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      chan_q  <= chan_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    chan_d  = chan_q;
    data_d  = data_q;
    mask_d  = mask_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          data_d = frame_data;
          mask_d = chan_mask;
          if (nc_found) begin
            state_d = S_DRIVE;
            chan_d  = nc_idx;
            cnt_d   = DWELL_LD;
          end else begin
            state_d = S_DONE;
            chan_d  = '0;
          end
        end
      end

      S_DRIVE: begin
        if (cnt_q == '0) begin
          if (nc_found) begin
            if (GAP == 0) begin
              state_d = S_DRIVE;
              chan_d  = nc_idx;
              cnt_d   = DWELL_LD;
            end else begin
              // chan_q is kept so the gap holds the previous channel's outputs.
              state_d = S_GAP;
              cnt_d   = GAP_LD;
            end
          end else begin
            state_d = S_DONE;
            chan_d  = '0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q == '0) begin
          state_d = S_DRIVE;
          chan_d  = nc_idx;
          cnt_d   = DWELL_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        chan_d  = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: registered outputs are computed from the next state, so
  // selects, data and Enable all update on the same edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    start_ready_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_DONE);
    enable_d      = (state_d == S_DRIVE);
    a_d           = 1'b0;
    s0_d          = 1'b0;
    s1_d          = 1'b0;
    active_chan_d = '0;
    if ((state_d == S_DRIVE) || (state_d == S_GAP)) begin
      a_d           = data_d[chan_d];
      s0_d          = chan_d[1];
      s1_d          = chan_d[0];
      active_chan_d = chan_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start_ready_q <= 1'b0;
      a_q           <= 1'b0;
      s0_q          <= 1'b0;
      s1_q          <= 1'b0;
      enable_q      <= 1'b0;
      active_chan_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      start_ready_q <= start_ready_d;
      a_q           <= a_d;
      s0_q          <= s0_d;
      s1_q          <= s1_d;
      enable_q      <= enable_d;
      active_chan_q <= active_chan_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign start_ready = start_ready_q;
  assign A           = a_q;
  assign S0          = s0_q;
  assign S1          = s1_q;
  assign Enable      = enable_q;
  assign active_chan = active_chan_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Testbench for demux_scan_sequencer (DWELL=4, GAP=1).
// Each frame vector lists cycle windows (offsets from the accept edge) with the
// expected output word {start_ready, busy, done, Enable, A, S0, S1, active_chan}.
module tb_demux_scan_sequencer;

  typedef struct packed {
    logic [7:0] lo;
    logic [7:0] hi;
    logic [8:0] exp;
  } seg_t;

  typedef struct packed {
    logic [3:0]      data;
    logic [3:0]      mask;
    logic [7:0]      last;
    logic [3:0]      nseg;
    seg_t [9:0]      seg;
  } frame_t;

  localparam int NFR = 7;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start_valid;
  logic       start_ready;
  logic [3:0] frame_data;
  logic [3:0] chan_mask;
  logic       A, S0, S1, Enable, busy, done;
  logic [1:0] active_chan;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  demux_scan_sequencer #(.DWELL(4), .GAP(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .frame_data  (frame_data),
    .chan_mask   (chan_mask),
    .A           (A),
    .S0          (S0),
    .S1          (S1),
    .Enable      (Enable),
    .active_chan (active_chan),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  logic [8:0] obs;
  assign obs = {start_ready, busy, done, Enable, A, S0, S1, active_chan};

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int         checks = 0;
  int         errors = 0;
  logic [8:0] exp_q[$];
  frame_t     frames [NFR];

  function automatic logic [8:0] mk(input logic rdy, input logic bsy, input logic dn,
                                     input logic en, input logic a,
                                     input logic [1:0] sel, input logic [1:0] ch);
    return {rdy, bsy, dn, en, a, sel, ch};
  endfunction

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b (rdy,busy,done,en,A,S0,S1,ch[1:0])", name, act, exp);
    end
  endtask

  task automatic new_frame(input int f, input logic [3:0] d, input logic [3:0] m, input int last);
    frames[f]      = '0;
    frames[f].data = d;
    frames[f].mask = m;
    frames[f].last = 8'(last);
  endtask

  task automatic add_seg(input int f, input int lo, input int hi, input logic [8:0] e);
    frames[f].seg[frames[f].nseg] = '{lo: 8'(lo), hi: 8'(hi), exp: e};
    frames[f].nseg = frames[f].nseg + 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic send(input int f, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!start_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!start_ready) begin
      checks++;
      errors++;
      $display("FAIL send_ready_timeout: got start_ready=0 want 1 within 100 cycles");
    end
    frame_data  = frames[f].data;
    chan_mask   = frames[f].mask;
    start_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start_valid = 1'b0;
  endtask

  // Called just after the accept edge; samples cycles N+1..N+upto on negedges.
  task automatic check_window(input int f, input int upto, input bit scramble);
    for (int off = 1; off <= upto; off++) begin
      logic [8:0] e;
      e = 9'h1FF;
      for (int s = 0; s < int'(frames[f].nseg); s++) begin
        if (off >= int'(frames[f].seg[s].lo) && off <= int'(frames[f].seg[s].hi))
          e = frames[f].seg[s].exp;
      end
      exp_q.push_back(e);
      @(negedge clk);
      check($sformatf("frame%0d_cyc%0d", f, off), obs, exp_q.pop_front());
      if (scramble) begin
        frame_data = 4'($urandom_range(0, 15));
        chan_mask  = 4'($urandom_range(0, 15));
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [8:0] idle_w;
    idle_w = mk(1, 0, 0, 0, 0, 2'b00, 2'd0);

    // 0: full frame, data 1010, mask 1111
    new_frame(0, 4'b1010, 4'b1111, 21);
    add_seg(0, 1, 4,   mk(0, 1, 0, 1, 0, 2'b00, 2'd0));
    add_seg(0, 5, 5,   mk(0, 1, 0, 0, 0, 2'b00, 2'd0));
    add_seg(0, 6, 9,   mk(0, 1, 0, 1, 1, 2'b01, 2'd1));
    add_seg(0, 10, 10, mk(0, 1, 0, 0, 1, 2'b01, 2'd1));
    add_seg(0, 11, 14, mk(0, 1, 0, 1, 0, 2'b10, 2'd2));
    add_seg(0, 15, 15, mk(0, 1, 0, 0, 0, 2'b10, 2'd2));
    add_seg(0, 16, 19, mk(0, 1, 0, 1, 1, 2'b11, 2'd3));
    add_seg(0, 20, 20, mk(0, 1, 1, 0, 0, 2'b00, 2'd0));
    add_seg(0, 21, 21, idle_w);
    // 1: sparse, data 1111, mask 0101
    new_frame(1, 4'b1111, 4'b0101, 11);
    add_seg(1, 1, 4,   mk(0, 1, 0, 1, 1, 2'b00, 2'd0));
    add_seg(1, 5, 5,   mk(0, 1, 0, 0, 1, 2'b00, 2'd0));
    add_seg(1, 6, 9,   mk(0, 1, 0, 1, 1, 2'b10, 2'd2));
    add_seg(1, 10, 10, mk(0, 1, 1, 0, 0, 2'b00, 2'd0));
    add_seg(1, 11, 11, idle_w);
    // 2: empty mask
    new_frame(2, 4'b1111, 4'b0000, 2);
    add_seg(2, 1, 1,   mk(0, 1, 1, 0, 0, 2'b00, 2'd0));
    add_seg(2, 2, 2,   idle_w);
    // 3: single top channel, data 0111, mask 1000
    new_frame(3, 4'b0111, 4'b1000, 6);
    add_seg(3, 1, 4,   mk(0, 1, 0, 1, 0, 2'b11, 2'd3));
    add_seg(3, 5, 5,   mk(0, 1, 1, 0, 0, 2'b00, 2'd0));
    add_seg(3, 6, 6,   idle_w);
    // 4: middle channels, data 0100, mask 0110
    new_frame(4, 4'b0100, 4'b0110, 11);
    add_seg(4, 1, 4,   mk(0, 1, 0, 1, 0, 2'b01, 2'd1));
    add_seg(4, 5, 5,   mk(0, 1, 0, 0, 0, 2'b01, 2'd1));
    add_seg(4, 6, 9,   mk(0, 1, 0, 1, 1, 2'b10, 2'd2));
    add_seg(4, 10, 10, mk(0, 1, 1, 0, 0, 2'b00, 2'd0));
    add_seg(4, 11, 11, idle_w);
    // 5: held-request first frame, data 1010, mask 0011
    new_frame(5, 4'b1010, 4'b0011, 11);
    add_seg(5, 1, 4,   mk(0, 1, 0, 1, 0, 2'b00, 2'd0));
    add_seg(5, 5, 5,   mk(0, 1, 0, 0, 0, 2'b00, 2'd0));
    add_seg(5, 6, 9,   mk(0, 1, 0, 1, 1, 2'b01, 2'd1));
    add_seg(5, 10, 10, mk(0, 1, 1, 0, 0, 2'b00, 2'd0));
    add_seg(5, 11, 11, idle_w);
    // 6: held-request second frame, data 0001, mask 0001
    new_frame(6, 4'b0001, 4'b0001, 6);
    add_seg(6, 1, 4,   mk(0, 1, 0, 1, 1, 2'b00, 2'd0));
    add_seg(6, 5, 5,   mk(0, 1, 1, 0, 0, 2'b00, 2'd0));
    add_seg(6, 6, 6,   idle_w);

    reset       = 1'b1;
    start_valid = 1'b0;
    frame_data  = 4'b0;
    chan_mask   = 4'b0;

    // Reset held 3 cycles: every output 0.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold", obs, 9'b0);
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_idle", obs, idle_w);

    // Table-driven frames.
    for (int f = 0; f < 5; f++) begin
      send(f, 1'b0);
      check_window(f, int'(frames[f].last), 1'b1);
    end

    // Reset during ch1 DRIVE (cycle N+7), then a normal frame.
    send(0, 1'b0);
    check_window(0, 7, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_clear", obs, 9'b0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("midrst_idle%0d", i), obs, idle_w);
    end
    send(1, 1'b0);
    check_window(1, int'(frames[1].last), 1'b1);

    // start_valid held with changing inputs; second frame taken in the idle cycle.
    send(5, 1'b1);
    check_window(5, int'(frames[5].last), 1'b1);
    frame_data = frames[6].data;
    chan_mask  = frames[6].mask;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    check_window(6, int'(frames[6].last), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, want completion within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
